// File: rtl/sccb_slave_regfile.sv
// SCCB/I2C target holding a 2^REG_AW x 8 register file (camera-sensor config port emulation).
// SCL/SDA are oversampled on PCLK; SDAO is an open-drain style drive (0 pulls low, 1 releases).
module sccb_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR    = 7'h21,
    parameter int         GLITCHREG_NUM = 3,
    parameter int         REG_AW        = 4
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       SCLI,
    input  logic       SDAI,
    output logic       SDAO,
    output logic       WR_STB,
    output logic [7:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    output logic       BUSY
);
    localparam int NREGS = 1 << REG_AW;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_EXTRA,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } state_t;

    logic [1:0]               scl_sync_q, sda_sync_q;
    logic [GLITCHREG_NUM-1:0] scl_hist_q, sda_hist_q;
    logic                     scl_f_q, sda_f_q, scl_prev_q, sda_prev_q;

    // Idle bus is high, so every conditioning stage resets to 1 to avoid a false START.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], SCLI};
            sda_sync_q <= {sda_sync_q[0], SDAI};
            scl_hist_q <= {scl_hist_q[GLITCHREG_NUM-2:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[GLITCHREG_NUM-2:0], sda_sync_q[1]};
            if (&scl_hist_q)       scl_f_q <= 1'b1;
            else if (~|scl_hist_q) scl_f_q <= 1'b0;
            if (&sda_hist_q)       sda_f_q <= 1'b1;
            else if (~|sda_hist_q) sda_f_q <= 1'b0;
            scl_prev_q <= scl_f_q;
            sda_prev_q <= sda_f_q;
        end
    end

    logic scl_rise, scl_fall, bus_start, bus_stop;
    assign scl_rise  =  scl_f_q & ~scl_prev_q;
    assign scl_fall  = ~scl_f_q &  scl_prev_q;
    assign bus_start =  scl_f_q &  scl_prev_q &  sda_prev_q & ~sda_f_q;
    assign bus_stop  =  scl_f_q &  scl_prev_q & ~sda_prev_q &  sda_f_q;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       ph_q, ph_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] ptr_q, ptr_d;
    logic       sdao_q, sdao_d;
    logic       busy_q, busy_d;
    logic       wr_stb_q, wr_stb_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       rf_we;
    logic [7:0] regs_q [NREGS];

    logic [7:0] byte_in;
    logic       ptr_in_range;
    logic [7:0] rd_byte;

    assign byte_in      = {sr_q[6:0], sda_f_q};
    assign ptr_in_range = (ptr_q >> REG_AW) == 8'd0;
    assign rd_byte      = ptr_in_range ? regs_q[ptr_q[REG_AW-1:0]] : 8'h00;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            ph_q      <= 1'b0;
            sr_q      <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            sdao_q    <= 1'b1;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ph_q      <= ph_d;
            sr_q      <= sr_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            sdao_q    <= sdao_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (rf_we) begin
            regs_q[ptr_q[REG_AW-1:0]] <= byte_in;
        end
    end

    // ph_q splits each ACK slot: first SCL fall starts the drive, second fall ends it.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        ph_d      = ph_q;
        sr_d      = sr_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        sdao_d    = sdao_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rf_we     = 1'b0;

        if (bus_start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            ph_d      = 1'b0;
            sdao_d    = 1'b1;
        end else if (bus_stop) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            ph_d      = 1'b0;
            sdao_d    = 1'b1;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_SUB, ST_WDATA: begin
                    if (scl_rise) begin
                        sr_d      = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            ph_d      = 1'b0;
                            case (state_q)
                                ST_ADDR: begin
                                    if (byte_in[7:1] == SLAVE_ADDR) begin
                                        state_d = ST_ADDR_ACK;
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = ST_IGNORE;
                                        busy_d  = 1'b0;
                                    end
                                end
                                ST_SUB: begin
                                    ptr_d   = byte_in;
                                    state_d = ST_SUB_ACK;
                                end
                                default: begin
                                    if (ptr_in_range) begin
                                        rf_we     = 1'b1;
                                        wr_stb_d  = 1'b1;
                                        wr_addr_d = ptr_q;
                                        wr_data_d = byte_in;
                                    end
                                    state_d = ST_WDATA_ACK;
                                end
                            endcase
                        end
                    end
                end
                ST_ADDR_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ph_q) begin
                            sdao_d = 1'b0;
                            ph_d   = 1'b1;
                        end else begin
                            ph_d   = 1'b0;
                            sdao_d = 1'b1;
                            case (state_q)
                                ST_ADDR_ACK: begin
                                    if (sr_q[0]) begin
                                        state_d = ST_RDATA;
                                        tx_d    = rd_byte;
                                        sdao_d  = rd_byte[7];
                                    end else begin
                                        state_d = ST_SUB;
                                    end
                                end
                                ST_SUB_ACK: state_d = ST_WDATA;
                                default:    state_d = ST_EXTRA;
                            endcase
                        end
                    end
                end
                ST_EXTRA: begin
                    // Surplus bytes are clocked through (8 data + released 9th) and dropped.
                    if (scl_rise) begin
                        bit_cnt_d = (bit_cnt_q == 4'd8) ? 4'd0 : bit_cnt_q + 4'd1;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sdao_d    = 1'b1;
                            state_d   = ST_RACK;
                            bit_cnt_d = '0;
                            ph_d      = 1'b0;
                        end else begin
                            tx_d   = {tx_q[6:0], 1'b0};
                            sdao_d = tx_q[6];
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        if (sda_f_q) state_d = ST_IGNORE;
                        else         ph_d    = 1'b1;
                    end else if (scl_fall && ph_q) begin
                        ph_d    = 1'b0;
                        tx_d    = rd_byte;
                        sdao_d  = rd_byte[7];
                        state_d = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SDAO    = sdao_q;
    assign WR_STB  = wr_stb_q;
    assign WR_ADDR = wr_addr_q;
    assign WR_DATA = wr_data_q;
    assign BUSY    = busy_q;

endmodule

// File: doc/sccb_slave_regfile.md
# sccb_slave_regfile

SCCB/I2C responder with a small internal 8-bit register file, answering the master-side I2C controller on the same two-wire bus. It emulates a camera sensor's configuration port: 3-phase writes (ID, sub-address, data) and 2-phase reads (ID+W, sub-address, then ID+R, data). The block oversamples SCL/SDA on the system clock and drives SDA open-drain style. It is used as the bus target in SCCB bring-up and as a loopback target for driver tests.

## Interface
- SLAVE_ADDR, 7'h21, 7-bit device ID; 8'h42 is write and 8'h43 is read.
- GLITCHREG_NUM, 3, consecutive identical synchronised samples required before a filtered SCL/SDA level changes.
- REG_AW, 4, register-file address width; the file holds 2^REG_AW bytes.

Ports:
- PCLK  in  1  system clock; all logic is on the rising edge.
- PRESETN  in  1  asynchronous active-low reset.
- SCLI  in  1  SCL pad input.
- SDAI  in  1  SDA pad input.
- SDAO  out  1  SDA drive: 0 pulls the line low, 1 releases it.
- WR_STB  out  1  one-cycle pulse when a register write commits.
- WR_ADDR  out  8  sub-address of the committed write.
- WR_DATA  out  8  data of the committed write.
- BUSY  out  1  high from an address-matched START until STOP.

## Operation
- **Input conditioning**
  - SCLI and SDAI each pass through a 2-flop synchroniser, then a glitch filter of GLITCHREG_NUM samples.
  - Edges are detected on the filtered levels.
- **Bus conditions**
  - START (and repeated START): filtered SDA falls while filtered SCL is high.
  - STOP: filtered SDA rises while filtered SCL is high.
  - START/STOP take priority over any bit activity in the same cycle.
- **Bit timing**
  - Inbound bits are sampled on the filtered SCL rising edge.
  - SDAO changes only in the cycle after a filtered SCL falling edge.
- **States**
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first.
  - ADDR_ACK: on ID match, drive 0 for the 9th bit. On mismatch, go to IGNORE.
  - SUB: shift 8 bits into the pointer register PTR.
  - SUB_ACK: ACK the byte, then go to WDATA.
  - WDATA: shift 8 bits. When the 8th bit is sampled, commit the write.
  - WDATA_ACK: ACK the byte, then go to EXTRA.
  - EXTRA: further bytes are not ACKed (SDA released for the 9th bit) and are discarded. SCCB does not auto-increment.
  - RDATA: drive bits of reg[PTR] MSB first.
  - RACK: release SDA and sample the master's 9th bit. Master ACK (0): resend reg[PTR] (no increment). Master NACK (1): go to IGNORE.
  - IGNORE: SDA released; wait for START/STOP.
- **Read and write selection**
  - An address byte with R/W=1 enters RDATA and uses the existing PTR.
  - PTR persists across transactions and resets to 0.
- **Write commit rules**
  - If WDATA address < 2^REG_AW: write reg[PTR], pulse WR_STB, and set WR_ADDR/WR_DATA. These outputs hold until the next commit.
  - If PTR ≥ 2^REG_AW: the byte is still ACKed, but there is no WR_STB and no write.
  - Reads of an out-of-range PTR return 8'h00.
- **Bus events**
  - Repeated START from any state goes to ADDR.
  - STOP from any state goes to IDLE and releases SDA.
  - BUSY is high from the ADDR_ACK match to STOP or to a non-matching repeated-START address.
- **Reset**
  - Reset mid-transfer returns to IDLE immediately.
  - All registers, PTR and shift state are cleared.

## Timing
- **Reset values:** SDAO=1, WR_STB=0, WR_ADDR=8'h00, WR_DATA=8'h00, BUSY=0, every reg[i]=8'h00, PTR=0.
- **Latency:**
  - SCLI pin edge to filtered edge: 2+GLITCHREG_NUM PCLK cycles.
  - SDAO update: one further cycle.
  - Minimum SCL high or low phase: GLITCHREG_NUM+4 PCLK cycles. Example: at 30 MHz PCLK, 100 kHz SCL has a large margin.
- **ACK drive:** SDAO=0 for exactly the 9th SCL low/high period. It is released on the falling edge that ends the 9th bit.
- **Write commit:** WR_STB pulses 1 cycle after the 8th data bit is sampled, before the ACK bit.
- **Read data:** reg[PTR] is latched into the TX shift register at the ADDR_ACK→RDATA transition and at each master ACK.

## Test plan
- **Basic write:** START, 0x42, 0x0A, 0x5C, STOP → three ACKs; one WR_STB with WR_ADDR=0x0A, WR_DATA=0x5C; reg[0x0A]=0x5C; BUSY returns to 0 after STOP.
- **Basic read:** START 0x42 0x0A STOP, then START 0x43, clock 8 bits, master NACK, STOP → SDA bits = 0x5C; SDAO=1 during the 9th bit.
- **ID mismatch:** START 0x44 0x0A 0x11 STOP → SDA never driven low; no WR_STB; BUSY stays 0.
- **Out-of-range and extra bytes:**
  - Write to 0x20 → ACKed, no WR_STB; a read returns 0x00.
  - Write 0x42 0x03 0xAA 0xBB → 4th byte not ACKed; reg[3]=0xAA.
- **Glitch and repeated START:**
  - A 2-cycle SCL low glitch during ADDR → ignored; the byte is still decoded correctly.
  - Repeated START 0x43 after a sub-address → read path taken without a STOP.
- **Reset mid-operation:** assert PRESETN low during WDATA bit 4 → SDAO=1 and BUSY=0 immediately; reg[0x0A]=0x00; the next full write succeeds.
